// File: rtl/upg_pkg.sv
// Shared types and helpers for the UART-programming (UPG) side of the memory loader.
package upg_pkg;

  typedef enum logic [2:0] {
    S_CNT0,
    S_CNT1,
    S_DATA,
    S_DONE,
    S_ERR
  } upg_state_e;

  localparam int UPG_ADDR_W      = 14;
  localparam int UPG_TIMEOUT_CYC = 100000;

  // Replace one little-endian byte lane of a 32-bit word.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // A packet may fill the target memory exactly but never exceed it.
  function automatic logic count_fits(input logic [15:0] n, input int addr_w);
    return ({16'b0, n} <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/upg_timeout_ctr.sv
// Idle-cycle counter: clears on demand, otherwise counts up and saturates at the limit.
module upg_timeout_ctr
  import upg_pkg::*;
#(
  parameter int TIMEOUT_CYC = UPG_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/upg_word_loader.sv
// Decodes a length-prefixed UART byte stream into little-endian 32-bit memory writes.
module upg_word_loader
  import upg_pkg::*;
#(
  parameter int ADDR_W      = UPG_ADDR_W,
  parameter int TIMEOUT_CYC = UPG_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_addr_o,
  output logic [31:0]       upg_data_o,
  output logic              upg_done_o,
  output logic              err_o,
  output logic              busy_o
);

  upg_state_e        state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic              last_q, last_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [15:0] n_rx;
  logic [31:0] word_in;
  logic        timing;
  logic        to_expire;

  assign n_rx    = {rx_data_i, cnt_lo_q};
  assign word_in = put_lane(asm_q, byte_idx_q, rx_data_i);
  // The strobe cycle of the final word is not part of the idle window.
  assign timing  = (state_q == S_CNT1) || ((state_q == S_DATA) && !last_q);

  upg_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start_i || rx_valid_i || !timing),
    .en_i    (1'b1),
    .expire_o(to_expire)
  );

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    waddr_d      = waddr_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    last_d       = last_q;
    wen_d        = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    done_d       = done_q;
    err_d        = err_q;

    if (start_i) begin
      state_d    = S_CNT0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      byte_idx_d = '0;
      waddr_d    = '0;
      last_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_CNT0: begin
          if (rx_valid_i) begin
            cnt_lo_d = rx_data_i;
            state_d  = S_CNT1;
          end
        end
        S_CNT1: begin
          if (rx_valid_i) begin
            if (n_rx == 16'd0) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (!count_fits(n_rx, ADDR_W)) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              words_left_d = n_rx;
              waddr_d      = '0;
              byte_idx_d   = '0;
              state_d      = S_DATA;
            end
          end else if (to_expire) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_DATA: begin
          if (last_q) begin
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (rx_valid_i) begin
            asm_d      = word_in;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              wen_d        = 1'b1;
              data_d       = word_in;
              addr_d       = waddr_q;
              waddr_d      = waddr_q + ADDR_W'(1);
              words_left_d = words_left_q - 16'd1;
              last_d       = (words_left_q == 16'd1);
            end
          end else if (to_expire) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CNT0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      waddr_q      <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      last_q       <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      waddr_q      <= waddr_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      last_q       <= last_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_addr_o = addr_q;
  assign upg_data_o = data_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q == S_CNT1) || (state_q == S_DATA);

endmodule

// File: tb/tb_upg_word_loader.sv
// Self-checking bench for upg_word_loader: directed corner cases plus randomized packets.
module tb_upg_word_loader;

  localparam int ADDR_W = 14;
  localparam int TO_CYC = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [7:0]        rx_data_i = '0;
  logic              rx_valid_i = 1'b0;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_addr_o;
  logic [31:0]       upg_data_o;
  logic              upg_done_o;
  logic              err_o;
  logic              busy_o;

  upg_word_loader #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .upg_wen_o (upg_wen_o),
    .upg_addr_o(upg_addr_o),
    .upg_data_o(upg_data_o),
    .upg_done_o(upg_done_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  wr_q[$];
  int   done_rise_q[$];
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (upg_wen_o) begin
      w.addr = int'(upg_addr_o);
      w.data = upg_data_o;
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
    if (upg_done_o && !done_prev) done_rise_q.push_back(cyc);
    done_prev <= upg_done_o;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Reference: a packet of words W[0..N-1] yields writes (i, W[i]) in order,
  // one cycle each, with done rising the cycle after the last write.
  logic [31:0] pkt_w[$];

  task automatic run_packet(input string tag, input int maxgap);
    logic [7:0] bytes[$];
    int n, base, dbase, seen;
    n = pkt_w.size();
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    foreach (pkt_w[i])
      for (int k = 0; k < 4; k++) bytes.push_back(8'(pkt_w[i] >> (8 * k)));
    base  = wr_q.size();
    dbase = done_rise_q.size();
    foreach (bytes[i]) begin
      if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
      send(bytes[i]);
    end
    idle(3);
    seen = wr_q.size() - base;
    check({tag, " nwrites"}, seen, n);
    for (int i = 0; i < n && i < seen; i++) begin
      check({tag, " addr"}, wr_q[base + i].addr, i);
      check({tag, " data"}, wr_q[base + i].data, pkt_w[i]);
    end
    check({tag, " done"}, upg_done_o, 1'b1);
    check({tag, " err"}, err_o, 1'b0);
    check({tag, " done_rises"}, done_rise_q.size() - dbase, 1);
    if (seen > 0 && done_rise_q.size() > dbase)
      check({tag, " done_timing"}, done_rise_q[dbase], wr_q[wr_q.size() - 1].cyc + 1);
    $display("[TB] packet %s: N=%0d words, %0d writes observed", tag, n, seen);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wen"}, upg_wen_o, 1'b0);
    check({tag, " addr"}, upg_addr_o, '0);
    check({tag, " data"}, upg_data_o, '0);
    check({tag, " done"}, upg_done_o, 1'b0);
    check({tag, " err"}, err_o, 1'b0);
    check({tag, " busy"}, busy_o, 1'b0);
  endtask

  initial begin
    int base;

    // Reset values
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Directed two-word packet, back-to-back bytes
    pkt_w = {};
    pkt_w.push_back(32'h12345678);
    pkt_w.push_back(32'hDEADBEEF);
    run_packet("directed", 0);

    // N = 0: done without writes, later bytes ignored
    pulse_start();
    check("start clears done", upg_done_o, 1'b0);
    base = wr_q.size();
    send(8'h00);
    send(8'h00);
    idle(2);
    check("n0 done", upg_done_o, 1'b1);
    check("n0 busy", busy_o, 1'b0);
    for (int i = 0; i < 6; i++) send(8'($urandom));
    idle(2);
    check("n0 no writes", wr_q.size() - base, 0);
    check("n0 done held", upg_done_o, 1'b1);
    $display("[TB] packet n0: empty packet, extra bytes ignored");

    // Oversize count
    pulse_start();
    base = wr_q.size();
    send(8'h01);
    send(8'h40);
    idle(2);
    check("oversize err", err_o, 1'b1);
    check("oversize busy", busy_o, 1'b0);
    check("oversize no writes", wr_q.size() - base, 0);
    pulse_start();
    check("start clears err", err_o, 1'b0);
    pkt_w = {};
    for (int i = 0; i < 3; i++) pkt_w.push_back($urandom);
    run_packet("after_err", 2);

    // Exactly full memory is accepted
    pulse_start();
    send(8'h00);
    send(8'h40);
    idle(1);
    check("full count busy", busy_o, 1'b1);
    check("full count err", err_o, 1'b0);
    pulse_start();
    check("start aborts busy", busy_o, 1'b0);
    $display("[TB] packet full_count: N=0x4000 accepted then aborted");

    // Timeout fires after TO_CYC idle cycles
    pulse_start();
    base = wr_q.size();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TO_CYC - 1);
    check("timeout not early", err_o, 1'b0);
    idle(1);
    check("timeout err", err_o, 1'b1);
    check("timeout busy", busy_o, 1'b0);
    check("timeout no writes", wr_q.size() - base, 0);
    $display("[TB] packet timeout: aborted after %0d idle cycles", TO_CYC);

    // Byte in the last allowed cycle wins over the timeout
    pulse_start();
    base = wr_q.size();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TO_CYC - 1);
    send(8'h33);
    send(8'h44);
    idle(3);
    check("late byte err", err_o, 1'b0);
    check("late byte nwrites", wr_q.size() - base, 1);
    if (wr_q.size() > base) begin
      check("late byte addr", wr_q[base].addr, 0);
      check("late byte data", wr_q[base].data, 32'h44332211);
    end
    check("late byte done", upg_done_o, 1'b1);
    $display("[TB] packet late_byte: byte at last idle cycle accepted");

    // start_i coinciding with a data byte discards it
    pulse_start();
    base = wr_q.size();
    send(8'h02); send(8'h00); send(8'hA1); send(8'hB2); send(8'hC3);
    rx_data_i  = 8'h05;
    rx_valid_i = 1'b1;
    start_i    = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    start_i    = 1'b0;
    check("start+byte busy", busy_o, 1'b0);
    check("start+byte no writes", wr_q.size() - base, 0);
    pkt_w = {};
    pkt_w.push_back($urandom);
    run_packet("after_start", 0);

    // Asynchronous reset mid-word
    pulse_start();
    base = wr_q.size();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("reset no writes", wr_q.size() - base, 0);
    pkt_w = {};
    for (int i = 0; i < 2; i++) pkt_w.push_back($urandom);
    run_packet("after_reset", 1);

    // Randomized packets
    for (int it = 0; it < 8; it++) begin
      pulse_start();
      pkt_w = {};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) pkt_w.push_back($urandom);
      run_packet($sformatf("rand%0d", it), (it % 2 == 1) ? 3 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
